module_control_unit: RTL and testbench
======================================

Name: module_control_unit

Overview:
Sequencing stage directly upstream of the 16-bit saturating ALU.
- Detects a send-button press and latches an 18-bit instruction from the switches.
- Reads an 8x16 register file and drives operands/opcode to the ALU.
- Writes the ALU result back and updates the display value.
- Owns all architectural state of the CPU. The ALU stays purely combinational.

Parameters:
- NUM_REGS, 8, register-file depth (fixed 8; index width 3).
- DATA_W, 16, register/operand width.
- DEBOUNCE_CYCLES, 250000, stable-level count (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- send_button  in  1  raw, asynchronous button level; active-high press.
- instr  in  18  [17:15] opcode, [14:12] rd, [11:9] rs1, [8:6] rs2, [8:0] imm9, [11:0] imm12.
- alu_result  in  16  combinational result from ALU.
- alu_operand_a  out  16  registered ALU operand A.
- alu_operand_b  out  16  registered ALU operand B.
- alu_opcode  out  3  registered ALU opcode.
- display_value  out  16  value shown on 7-seg driver.
- display_reg  out  3  register index shown.
- busy  out  1  high whenever state != IDLE.
- instr_done  out  1  one-cycle pulse at instruction completion.

Behaviour:
- Reset values (async):
  - All registers R0..R7 = 0.
  - All outputs = 0.
  - State = IDLE.
  - Synchronizer flops = 0.
- Reset asserted mid-instruction aborts it; no partial writeback survives.
- Button input path:
  - 2-flop synchronizer, then rising-edge detect (press_pulse, 1 cycle).
  - Press_pulse is accepted only in IDLE. Presses while busy are dropped, not queued.
- Opcodes: 0 LOAD, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 MUL, 6 CLEAR, 7 DISPLAY.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE. No stalls; fixed 4 cycles from accept to instr_done.
- IDLE, on press_pulse: instr_q <= instr; go to READ.
- READ: register operands and opcode to the ALU.
  - ADD/SUB/MUL: alu_operand_a = R[rs1], alu_operand_b = R[rs2].
  - ADDI/SUBI: alu_operand_a = R[rs1], alu_operand_b = sign_extend(imm9).
  - LOAD/CLEAR/DISPLAY: both operands = 0.
  - alu_opcode = instr_q opcode in all cases.
- EXEC: ALU result settles; result_q <= alu_result. Nothing else changes.
- WRITE:
  - ADD..MUL: R[rd] <= result_q; display_value <= result_q; display_reg <= rd.
  - LOAD: R[rd] <= sign_extend(imm12); display_value <= the same value; display_reg <= rd.
  - CLEAR: all R <= 0; display_value <= 0; display_reg <= 0.
  - DISPLAY: display_value <= R[rs1]; display_reg <= rs1; no register write.
- DONE: instr_done = 1 for exactly this cycle; go to IDLE.
- Width and hazard rules:
  - The ALU saturates to 0x7FFF/0x8000. The controller stores alu_result verbatim with no re-clamping.
  - All immediates are two's-complement sign-extended to 16 bits.
  - R0 is an ordinary writable register.
  - rd == rs1 or rd == rs2 is legal; reads happen in READ, before WRITE, so the old value is used.
- Simultaneous reset and press: reset wins.
- Button held high produces exactly one instruction; the next instruction requires release then re-press.

Optional Feature:
- Macro: CONTROL_DEBOUNCE_EN.
- Defined:
  - A counter after the synchronizer requires the synchronized level to be stable for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes.
  - Edge detect operates on the debounced level.
  - A bounce shorter than DEBOUNCE_CYCLES produces no press_pulse.
- Undefined: edge detect operates directly on the synchronized level, and the counter is not synthesized.

Decomposition:
- Package module_cpu_pkg holds:
  - Opcode constants LOAD..DISPLAY (values 0..7).
  - FSM state encoding.
  - Instruction field bit positions.
  - DATA_W and REG_IDX_W = 3.
  - Sign-extend helper functions for 9- and 12-bit immediates.
- One sub-module, module_button_sync: synchronizer, optional debounce, rising-edge pulse. Ports clk, reset, button_in, press_pulse.

Test Plan:
- Reset, then LOAD R1,5 (instr = 18'b000_001_000000000101) -> instr_done 4 cycles after press_pulse; R1 = 5; display_value = 0x0005; display_reg = 1.
- Continuing, ADDI R2,R1,-3 (imm9 = 0x1FD) -> alu_operand_b = 0xFFFD; R2 = 2; display_value = 0x0002.
- LOAD R1,300 and LOAD R2,200, then MUL R3,R1,R2 -> ALU saturates; R3 = 0x7FFF. Then LOAD R4,-2048 followed by ADD R4,R4,R4 -> R4 = 0xF000 (no saturation).
- Second press while busy (during EXEC) -> ignored; exactly one instr_done; a held button yields one instruction.
- DISPLAY rs1=3 -> display_value = 0x7FFF, display_reg = 3, registers unchanged. Then CLEAR -> all registers and display_value = 0.
- Reset asserted during WRITE of LOAD R5,7 -> R5 = 0, busy = 0, no instr_done. With CONTROL_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4, a 2-cycle glitch -> no instruction.

Source files
------------

// File: rtl/module_cpu_pkg.sv
// module_cpu_pkg: shared opcodes, FSM encoding, instruction field layout and immediate sign-extension for the CPU controller.
package module_cpu_pkg;
    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int INSTR_W   = 18;
    localparam int OPC_LSB   = 15;
    localparam int RD_LSB    = 12;
    localparam int RS1_LSB   = 9;
    localparam int RS2_LSB   = 6;
    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction
    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return {{(DATA_W-12){v[11]}}, v};
    endfunction
endpackage

// File: rtl/module_button_sync.sv
// module_button_sync: 2-flop synchronizer and rising-edge pulse for the send button.
// With CONTROL_DEBOUNCE_EN defined, a stability counter filters the synchronized level first.
module module_button_sync
`ifdef CONTROL_DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYCLES = 250000)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic press_pulse
);
    logic s1, s2, lvl, lvl_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            s1    <= button_in;
            s2    <= s1;
            lvl_q <= lvl;
        end
`ifdef CONTROL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          deb;
    logic [CW-1:0] cnt;
    // The debounced level follows s2 only after it has differed for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    assign lvl = deb;
`else
    assign lvl = s2;
`endif
    assign press_pulse = lvl & ~lvl_q;
endmodule

// File: rtl/module_control_unit.sv
// module_control_unit: button-triggered instruction sequencer and register file feeding a combinational saturating ALU.
// CONTROL_DEBOUNCE_EN enables the button debounce counter.
module module_control_unit #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16
`ifdef CONTROL_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 250000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_button,
    input  logic [17:0]       instr,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] display_value,
    output logic [2:0]        display_reg,
    output logic              busy,
    output logic              instr_done
);
    import module_cpu_pkg::*;
    state_t                      state, next;
    logic [INSTR_W-1:0]          instr_q;
    logic [DATA_W-1:0]           result_q, a_d, b_d, wb, disp_d;
    logic [DATA_W-1:0]           regs [NUM_REGS];
    logic [2:0]                  opc, disp_r;
    logic [REG_IDX_W-1:0]        rd, rs1, rs2;
    logic                        press_pulse, rr_op, imm_op;

    module_button_sync
`ifdef CONTROL_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_sync (.clk(clk), .reset(reset), .button_in(send_button), .press_pulse(press_pulse));

    assign opc = instr_q[OPC_LSB +: 3];
    assign rd  = instr_q[RD_LSB +: REG_IDX_W];
    assign rs1 = instr_q[RS1_LSB +: REG_IDX_W];
    assign rs2 = instr_q[RS2_LSB +: REG_IDX_W];
    assign busy       = state != IDLE;
    assign instr_done = state == DONE;

    always_comb begin
        next   = state == IDLE  ? (press_pulse ? READ : IDLE) :
                 state == READ  ? EXEC :
                 state == EXEC  ? WRITE :
                 state == WRITE ? DONE : IDLE;
        rr_op  = opc == OP_ADD || opc == OP_SUB || opc == OP_MUL;
        imm_op = opc == OP_ADDI || opc == OP_SUBI;
        a_d    = (rr_op || imm_op) ? regs[rs1] : '0;
        b_d    = imm_op ? sext9(instr_q[8:0]) : rr_op ? regs[rs2] : '0;
        wb     = opc == OP_LOAD ? sext12(instr_q[11:0]) : result_q;
        disp_d = opc == OP_CLEAR ? '0 : opc == OP_DISPLAY ? regs[rs1] : wb;
        disp_r = opc == OP_CLEAR ? 3'd0 : opc == OP_DISPLAY ? rs1 : rd;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state         <= IDLE;
            instr_q       <= '0;
            result_q      <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_opcode    <= '0;
            display_value <= '0;
            display_reg   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= next;
            if (state == IDLE && press_pulse) instr_q <= instr;
            if (state == READ) begin
                alu_operand_a <= a_d;
                alu_operand_b <= b_d;
                alu_opcode    <= opc;
            end
            if (state == EXEC) result_q <= alu_result;
            if (state == WRITE) begin
                if (opc == OP_CLEAR)
                    for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                else if (opc != OP_DISPLAY)
                    regs[rd] <= wb;
                display_value <= disp_d;
                display_reg   <= disp_r;
            end
        end
endmodule

// File: tb/tb_module_control_unit.sv
// tb_module_control_unit: directed scenarios against a bench-side saturating ALU model.
module tb_module_control_unit;
    import module_cpu_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, send_button = 1'b0;
    logic [17:0] instr = '0;
    logic [15:0] alu_result, alu_operand_a, alu_operand_b, display_value;
    logic [2:0]  alu_opcode, display_reg;
    logic        busy, instr_done;
    int          compared = 0, mismatched = 0;
    int          n, dones;
`ifdef CONTROL_DEBOUNCE_EN
    localparam int LAT = 10;
    module_control_unit #(.DEBOUNCE_CYCLES(4)) dut (
`else
    localparam int LAT = 6;
    module_control_unit dut (
`endif
        .clk(clk), .reset(reset), .send_button(send_button), .instr(instr),
        .alu_result(alu_result), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_opcode(alu_opcode), .display_value(display_value), .display_reg(display_reg),
        .busy(busy), .instr_done(instr_done));

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic signed [31:0] p;
        case (op)
            OP_ADD, OP_ADDI: p = $signed(a) + $signed(b);
            OP_SUB, OP_SUBI: p = $signed(a) - $signed(b);
            OP_MUL:          p = $signed(a) * $signed(b);
            default:         p = 0;
        endcase
        return p > 32767 ? 16'h7FFF : p < -32768 ? 16'h8000 : p[15:0];
    endfunction
    assign alu_result = alu_model(alu_operand_a, alu_operand_b, alu_opcode);

    function automatic logic [17:0] rr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        return {op, d, s1, s2, 6'b0};
    endfunction
    function automatic logic [17:0] ri9(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [8:0] imm);
        return {op, d, s1, imm};
    endfunction
    function automatic logic [17:0] ri12(input logic [2:0] op, input logic [2:0] d, input logic [11:0] imm);
        return {op, d, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] i, output int cycles);
        instr = i;
        send_button = 1'b1;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!instr_done && cycles < 40);
        send_button = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (instr_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", instr_done); end
        compared++; if (display_value !== 16'h0) begin mismatched++; $display("FAIL reset_disp: got %h want 0000", display_value); end
        compared++; if (display_reg !== 3'd0) begin mismatched++; $display("FAIL reset_dreg: got %0d want 0", display_reg); end
        compared++; if ({alu_operand_a, alu_operand_b, alu_opcode} !== 35'h0) begin mismatched++; $display("FAIL reset_alu: got %h/%h/%0d want 0", alu_operand_a, alu_operand_b, alu_opcode); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        send(ri12(OP_LOAD, 3'd1, 12'd5), n);
        compared++; if (n !== LAT) begin mismatched++; $display("FAIL load_latency: got %0d want %0d", n, LAT); end
        compared++; if (display_value !== 16'h0005) begin mismatched++; $display("FAIL load_disp: got %h want 0005", display_value); end
        compared++; if (display_reg !== 3'd1) begin mismatched++; $display("FAIL load_dreg: got %0d want 1", display_reg); end
    endtask

    task automatic test_addi();
        send(ri9(OP_ADDI, 3'd2, 3'd1, 9'h1FD), n);
        compared++; if (alu_operand_b !== 16'hFFFD) begin mismatched++; $display("FAIL addi_opb: got %h want FFFD", alu_operand_b); end
        compared++; if (alu_operand_a !== 16'h0005) begin mismatched++; $display("FAIL addi_opa: got %h want 0005", alu_operand_a); end
        compared++; if (alu_opcode !== OP_ADDI) begin mismatched++; $display("FAIL addi_opc: got %0d want 2", alu_opcode); end
        compared++; if ({display_reg, display_value} !== {3'd2, 16'h0002}) begin mismatched++; $display("FAIL addi_res: got R%0d=%h want R2=0002", display_reg, display_value); end
    endtask

    task automatic test_arith();
        send(ri12(OP_LOAD, 3'd1, 12'd300), n);
        send(ri12(OP_LOAD, 3'd2, 12'd200), n);
        send(rr(OP_MUL, 3'd3, 3'd1, 3'd2), n);
        compared++; if ({display_reg, display_value} !== {3'd3, 16'h7FFF}) begin mismatched++; $display("FAIL mul_sat: got R%0d=%h want R3=7FFF", display_reg, display_value); end
        send(ri12(OP_LOAD, 3'd4, 12'h800), n);
        compared++; if (display_value !== 16'hF800) begin mismatched++; $display("FAIL load_neg: got %h want F800", display_value); end
        send(rr(OP_ADD, 3'd4, 3'd4, 3'd4), n);
        compared++; if ({display_reg, display_value} !== {3'd4, 16'hF000}) begin mismatched++; $display("FAIL add_self: got R%0d=%h want R4=F000", display_reg, display_value); end
        send(rr(OP_SUB, 3'd5, 3'd2, 3'd1), n);
        compared++; if ({display_reg, display_value} !== {3'd5, 16'hFF9C}) begin mismatched++; $display("FAIL sub: got R%0d=%h want R5=FF9C", display_reg, display_value); end
        send(ri9(OP_SUBI, 3'd0, 3'd2, 9'd50), n);
        compared++; if ({display_reg, display_value} !== {3'd0, 16'h0096}) begin mismatched++; $display("FAIL subi_r0: got R%0d=%h want R0=0096", display_reg, display_value); end
    endtask

    task automatic test_back_to_back();
        instr = ri12(OP_LOAD, 3'd6, 12'd9);
        send_button = 1'b1;
        n = 0;
        while (!busy && n < 40) begin tick(); n++; end
        send_button = 1'b0;
        tick();
        send_button = 1'b1;
        dones = 0;
        repeat (30) begin tick(); if (instr_done) dones++; end
        compared++; if (dones !== 1) begin mismatched++; $display("FAIL busy_press: got %0d completions want 1", dones); end
        compared++; if ({display_reg, display_value} !== {3'd6, 16'h0009}) begin mismatched++; $display("FAIL busy_load: got R%0d=%h want R6=0009", display_reg, display_value); end
        send_button = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic test_display_clear();
        send(ri9(OP_DISPLAY, 3'd0, 3'd3, 9'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd3, 16'h7FFF}) begin mismatched++; $display("FAIL display_r3: got R%0d=%h want R3=7FFF", display_reg, display_value); end
        send(ri9(OP_DISPLAY, 3'd0, 3'd1, 9'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd1, 16'h012C}) begin mismatched++; $display("FAIL display_r1: got R%0d=%h want R1=012C", display_reg, display_value); end
        send(ri12(OP_CLEAR, 3'd5, 12'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd0, 16'h0000}) begin mismatched++; $display("FAIL clear: got R%0d=%h want R0=0000", display_reg, display_value); end
        send(ri9(OP_DISPLAY, 3'd0, 3'd3, 9'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd3, 16'h0000}) begin mismatched++; $display("FAIL clear_r3: got R%0d=%h want R3=0000", display_reg, display_value); end
        send(ri9(OP_DISPLAY, 3'd0, 3'd6, 9'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd6, 16'h0000}) begin mismatched++; $display("FAIL clear_r6: got R%0d=%h want R6=0000", display_reg, display_value); end
    endtask

    task automatic test_reset_mid();
        send(ri12(OP_LOAD, 3'd5, 12'd3), n);
        instr = ri12(OP_LOAD, 3'd5, 12'd7);
        send_button = 1'b1;
        n = 0;
        while (!busy && n < 40) begin tick(); n++; end
        repeat (2) tick();
        reset = 1'b1;
        #1;
        compared++; if ({busy, instr_done} !== 2'b00) begin mismatched++; $display("FAIL rst_mid_state: got busy=%b done=%b want 0/0", busy, instr_done); end
        compared++; if (display_value !== 16'h0000) begin mismatched++; $display("FAIL rst_mid_disp: got %h want 0000", display_value); end
        send_button = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        dones = 0;
        repeat (LAT + 5) begin tick(); if (instr_done) dones++; end
        compared++; if (dones !== 0) begin mismatched++; $display("FAIL rst_mid_done: got %0d completions want 0", dones); end
        send(ri9(OP_DISPLAY, 3'd0, 3'd5, 9'd0), n);
        compared++; if ({display_reg, display_value} !== {3'd5, 16'h0000}) begin mismatched++; $display("FAIL rst_mid_r5: got R%0d=%h want R5=0000", display_reg, display_value); end
    endtask

`ifdef CONTROL_DEBOUNCE_EN
    task automatic test_debounce();
        instr = ri12(OP_LOAD, 3'd7, 12'd1);
        send_button = 1'b1;
        repeat (2) tick();
        send_button = 1'b0;
        dones = 0;
        repeat (15) begin tick(); if (instr_done || busy) dones++; end
        compared++; if (dones !== 0) begin mismatched++; $display("FAIL glitch: got %0d active cycles want 0", dones); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_addi();
        test_arith();
        test_back_to_back();
        test_display_clear();
        test_reset_mid();
`ifdef CONTROL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
